// File: rtl/trap_sequencer.sv
// Trap/return sequencer between execute and the machine CSR file.
// Picks one trap or mret per event and walks its CSR writes over one port.
module trap_sequencer #(
    parameter bit VECTORED_EN = 1'b1,
    parameter bit INT_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_iam,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_ld_mis,
    input  logic        exc_ld_acc,
    input  logic        exc_st_mis,
    input  logic        exc_st_acc,
    input  logic        is_mret,
    input  logic        irq_mei,
    input  logic        irq_msi,
    input  logic        irq_mti,
    input  logic [1:0]  priv_mode,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] mem_addr,
    output logic        busy,
    output logic        csr_wr_req,
    output logic [11:0] csr_wr_addr,
    output logic [31:0] csr_wr_data,
    input  logic        csr_wr_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        priv_set_valid,
    output logic [1:0]  priv_set_val,
    output logic        trap_taken
);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, M_STAT, REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] stat_q, stat_d;
    logic [31:0] tgt_q, tgt_d;
    logic [1:0]  prv_q, prv_d;
    logic        trap_q, trap_d;

    logic        exc, irq, evt;
    logic [3:0]  exc_code, irq_code;
    logic [31:0] exc_tval;
    logic [31:0] base;

    assign exc = exc_iam | exc_illegal | exc_ebreak | exc_ecall |
                 exc_ld_mis | exc_ld_acc | exc_st_mis | exc_st_acc;
    assign irq = INT_EN & (irq_mei | irq_msi | irq_mti) &
                 (mstatus[3] | (priv_mode != 2'b11));
    assign evt  = exc | irq | is_mret;
    assign base = {mtvec[31:2], 2'b00};

    // Highest-priority exception and interrupt codes with their tval
    always_comb begin
        exc_code = 4'd0;
        exc_tval = 32'd0;
        priority case (1'b1)
            exc_ebreak:  begin exc_code = 4'd3; exc_tval = pc;       end
            exc_iam:     begin exc_code = 4'd0; exc_tval = pc;       end
            exc_illegal: begin exc_code = 4'd2; exc_tval = instr;    end
            exc_ecall: begin
                exc_tval = 32'd0;
                case (priv_mode)
                    2'b00:   exc_code = 4'd8;
                    2'b01:   exc_code = 4'd9;
                    default: exc_code = 4'd11;
                endcase
            end
            exc_ld_mis:  begin exc_code = 4'd4; exc_tval = mem_addr; end
            exc_st_mis:  begin exc_code = 4'd6; exc_tval = mem_addr; end
            exc_ld_acc:  begin exc_code = 4'd5; exc_tval = mem_addr; end
            exc_st_acc:  begin exc_code = 4'd7; exc_tval = mem_addr; end
            default:     begin exc_code = 4'd0; exc_tval = 32'd0;    end
        endcase
        irq_code = 4'd7;
        priority case (1'b1)
            irq_mei: irq_code = 4'd11;
            irq_msi: irq_code = 4'd3;
            default: irq_code = 4'd7;
        endcase
    end

    // State and latched event context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            stat_q  <= '0;
            tgt_q   <= '0;
            prv_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            stat_q  <= stat_d;
            tgt_q   <= tgt_d;
            prv_q   <= prv_d;
            trap_q  <= trap_d;
        end
    end

    // Next state, event latch and CSR/redirect outputs
    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        tval_d         = tval_q;
        stat_d         = stat_q;
        tgt_d          = tgt_q;
        prv_d          = prv_q;
        trap_d         = trap_q;
        csr_wr_req     = 1'b0;
        csr_wr_addr    = 12'h000;
        csr_wr_data    = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        priv_set_valid = 1'b0;
        priv_set_val   = 2'b00;
        trap_taken     = 1'b0;
        busy           = ~rst & ((state_q != IDLE) | evt);
        unique case (state_q)
            IDLE: begin
                if (exc | irq) begin
                    state_d = W_EPC;
                    epc_d   = pc;
                    trap_d  = 1'b1;
                    prv_d   = 2'b11;
                    stat_d  = mstatus;
                    stat_d[12:11] = priv_mode;
                    stat_d[7] = mstatus[3];
                    stat_d[3] = 1'b0;
                    if (exc) begin
                        cause_d = {28'd0, exc_code};
                        tval_d  = exc_tval;
                        tgt_d   = base;
                    end else begin
                        cause_d = {1'b1, 27'd0, irq_code};
                        tval_d  = 32'd0;
                        tgt_d   = base;
                        if (VECTORED_EN && mtvec[1:0] == 2'b01)
                            tgt_d = base + {26'd0, irq_code, 2'b00};
                    end
                end else if (is_mret) begin
                    state_d = M_STAT;
                    trap_d  = 1'b0;
                    tgt_d   = mepc;
                    prv_d   = mstatus[12:11];
                    stat_d  = mstatus;
                    stat_d[3] = mstatus[7];
                    stat_d[7] = 1'b1;
                    stat_d[12:11] = 2'b00;
                end
            end
            W_EPC: begin
                csr_wr_req  = 1'b1;
                csr_wr_addr = 12'h341;
                csr_wr_data = epc_q;
                if (csr_wr_ack) state_d = W_CAUSE;
            end
            W_CAUSE: begin
                csr_wr_req  = 1'b1;
                csr_wr_addr = 12'h342;
                csr_wr_data = cause_q;
                if (csr_wr_ack) state_d = W_TVAL;
            end
            W_TVAL: begin
                csr_wr_req  = 1'b1;
                csr_wr_addr = 12'h343;
                csr_wr_data = tval_q;
                if (csr_wr_ack) state_d = W_STAT;
            end
            W_STAT, M_STAT: begin
                csr_wr_req  = 1'b1;
                csr_wr_addr = 12'h300;
                csr_wr_data = stat_q;
                if (csr_wr_ack) state_d = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                priv_set_valid = 1'b1;
                priv_set_val   = prv_q;
                trap_taken     = trap_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap, vectored irq, priority,
// mret, ack back-pressure and mid-handshake reset.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_iam, exc_illegal, exc_ebreak, exc_ecall;
    logic        exc_ld_mis, exc_ld_acc, exc_st_mis, exc_st_acc;
    logic        is_mret, irq_mei, irq_msi, irq_mti;
    logic [1:0]  priv_mode;
    logic [31:0] mstatus, mtvec, mepc, pc, instr, mem_addr;
    logic        csr_wr_ack;

    logic        busy, csr_wr_req, redirect_valid, priv_set_valid, trap_taken;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data, redirect_pc;
    logic [1:0]  priv_set_val;

    logic        n_busy, n_req, n_rv, n_psv, n_tt;
    logic [11:0] n_addr;
    logic [31:0] n_data, n_pc;
    logic [1:0]  n_psval;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.VECTORED_EN(1'b1), .INT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .exc_iam(exc_iam), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_ld_mis(exc_ld_mis), .exc_ld_acc(exc_ld_acc),
        .exc_st_mis(exc_st_mis), .exc_st_acc(exc_st_acc),
        .is_mret(is_mret), .irq_mei(irq_mei), .irq_msi(irq_msi),
        .irq_mti(irq_mti), .priv_mode(priv_mode), .mstatus(mstatus),
        .mtvec(mtvec), .mepc(mepc), .pc(pc), .instr(instr),
        .mem_addr(mem_addr), .busy(busy), .csr_wr_req(csr_wr_req),
        .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .csr_wr_ack(csr_wr_ack), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .priv_set_valid(priv_set_valid),
        .priv_set_val(priv_set_val), .trap_taken(trap_taken)
    );

    trap_sequencer #(.VECTORED_EN(1'b0), .INT_EN(1'b1)) u_nv (
        .clk(clk), .rst(rst),
        .exc_iam(exc_iam), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_ld_mis(exc_ld_mis), .exc_ld_acc(exc_ld_acc),
        .exc_st_mis(exc_st_mis), .exc_st_acc(exc_st_acc),
        .is_mret(is_mret), .irq_mei(irq_mei), .irq_msi(irq_msi),
        .irq_mti(irq_mti), .priv_mode(priv_mode), .mstatus(mstatus),
        .mtvec(mtvec), .mepc(mepc), .pc(pc), .instr(instr),
        .mem_addr(mem_addr), .busy(n_busy), .csr_wr_req(n_req),
        .csr_wr_addr(n_addr), .csr_wr_data(n_data),
        .csr_wr_ack(csr_wr_ack), .redirect_valid(n_rv),
        .redirect_pc(n_pc), .priv_set_valid(n_psv),
        .priv_set_val(n_psval), .trap_taken(n_tt)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {exc_iam, exc_illegal, exc_ebreak, exc_ecall} = 4'b0;
        {exc_ld_mis, exc_ld_acc, exc_st_mis, exc_st_acc} = 4'b0;
        {is_mret, irq_mei, irq_msi, irq_mti} = 4'b0;
    endtask

    // Cycle 0: event inputs already driven; clear them after the edge
    task automatic fire(input string tag);
        @(negedge clk);
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_req0"}, 32'(csr_wr_req), 32'd0);
        tick();
        clr();
    endtask

    task automatic wr(input string tag, input logic [11:0] a,
                      input logic [31:0] d);
        @(negedge clk);
        chk({tag, "_req"}, 32'(csr_wr_req), 32'd1);
        chk({tag, "_addr"}, 32'(csr_wr_addr), 32'(a));
        chk({tag, "_data"}, csr_wr_data, d);
        tick();
    endtask

    task automatic redir(input string tag, input logic [31:0] p,
                         input logic [31:0] pnv, input logic [1:0] prv,
                         input logic tt);
        @(negedge clk);
        chk({tag, "_rv"}, 32'(redirect_valid), 32'd1);
        chk({tag, "_pc"}, redirect_pc, p);
        chk({tag, "_pc_nv"}, n_pc, pnv);
        chk({tag, "_psv"}, 32'(priv_set_valid), 32'd1);
        chk({tag, "_prv"}, 32'(priv_set_val), 32'(prv));
        chk({tag, "_tt"}, 32'(trap_taken), 32'(tt));
        chk({tag, "_req"}, 32'(csr_wr_req), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_rv"}, 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        csr_wr_ack = 1'b1;
        priv_mode = 2'b11;
        mstatus = 32'h8;
        mtvec = 32'h8000_0100;
        mepc = 32'h0;
        pc = 32'h0;
        instr = 32'h0;
        mem_addr = 32'h0;
        exc_illegal = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(csr_wr_req), 32'd0);
        chk("rst_rv", 32'(redirect_valid), 32'd0);
        tick();
        clr();
        rst = 1'b0;
        tick();

        // Illegal instruction in M mode
        pc = 32'h200;
        instr = 32'hFFFF_FFFF;
        exc_illegal = 1'b1;
        fire("t1");
        wr("t1_epc", 12'h341, 32'h200);
        wr("t1_cause", 12'h342, 32'd2);
        wr("t1_tval", 12'h343, 32'hFFFF_FFFF);
        wr("t1_stat", 12'h300, 32'h1880);
        redir("t1", 32'h8000_0100, 32'h8000_0100, 2'b11, 1'b1);

        // Vectored timer interrupt
        tick();
        mtvec = 32'h8000_0101;
        pc = 32'h300;
        irq_mti = 1'b1;
        fire("t2");
        wr("t2_epc", 12'h341, 32'h300);
        wr("t2_cause", 12'h342, 32'h8000_0007);
        wr("t2_tval", 12'h343, 32'h0);
        wr("t2_stat", 12'h300, 32'h1880);
        redir("t2", 32'h8000_011C, 32'h8000_0100, 2'b11, 1'b1);

        // ecall + ld_mis + mei from U mode: ecall wins, no vectoring
        tick();
        priv_mode = 2'b00;
        pc = 32'h500;
        mem_addr = 32'h1234;
        exc_ecall = 1'b1;
        exc_ld_mis = 1'b1;
        irq_mei = 1'b1;
        fire("t3");
        wr("t3_epc", 12'h341, 32'h500);
        wr("t3_cause", 12'h342, 32'd8);
        wr("t3_tval", 12'h343, 32'h0);
        wr("t3_stat", 12'h300, 32'h80);
        redir("t3", 32'h8000_0100, 32'h8000_0100, 2'b11, 1'b1);

        // mret back to U mode
        tick();
        priv_mode = 2'b11;
        mstatus = 32'h80;
        mepc = 32'h400;
        is_mret = 1'b1;
        fire("t4");
        wr("t4_stat", 12'h300, 32'h88);
        redir("t4", 32'h400, 32'h400, 2'b00, 1'b0);

        // ebreak with 3 ack wait cycles on mcause
        tick();
        mstatus = 32'h8;
        pc = 32'h600;
        exc_ebreak = 1'b1;
        fire("t5");
        wr("t5_epc", 12'h341, 32'h600);
        csr_wr_ack = 1'b0;
        wr("t5_w1", 12'h342, 32'd3);
        wr("t5_w2", 12'h342, 32'd3);
        wr("t5_w3", 12'h342, 32'd3);
        csr_wr_ack = 1'b1;
        wr("t5_cause", 12'h342, 32'd3);
        wr("t5_tval", 12'h343, 32'h600);
        wr("t5_stat", 12'h300, 32'h1880);
        redir("t5", 32'h8000_0100, 32'h8000_0100, 2'b11, 1'b1);

        // Reset while waiting on mtval
        tick();
        pc = 32'h700;
        exc_ebreak = 1'b1;
        fire("t6");
        wr("t6_epc", 12'h341, 32'h700);
        wr("t6_cause", 12'h342, 32'd3);
        csr_wr_ack = 1'b0;
        @(negedge clk);
        chk("t6_tval_req", 32'(csr_wr_req), 32'd1);
        chk("t6_tval_addr", 32'(csr_wr_addr), 32'h343);
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(csr_wr_req), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_addr", 32'(csr_wr_addr), 32'd0);
        #1;
        rst = 1'b0;
        csr_wr_ack = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_req", 32'(csr_wr_req), 32'd0);
        tick();
        pc = 32'h800;
        exc_iam = 1'b1;
        fire("t7");
        wr("t7_epc", 12'h341, 32'h800);
        wr("t7_cause", 12'h342, 32'd0);
        wr("t7_tval", 12'h343, 32'h800);
        wr("t7_stat", 12'h300, 32'h1880);
        redir("t7", 32'h8000_0100, 32'h8000_0100, 2'b11, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
